fsm_steer_driver: RTL and testbench

- Stimulus-side companion to the group's 4-state control FSM. The FSM takes inputs A/B/C/D and presents its 2-bit state code on an out bus: S0=00, S1=01, S2=10, S3=11.
- Accepts a target-state request, drives the FSM's A/B/C/D one legal hop at a time, and checks the observed state after each hop.
- Reports done, or an error with a code. Used in the security-verification harness to walk the FSM and detect illegal or missing transitions.

---
 rtl/fsm_steer_driver.sv | 188 ++++++++++++++++++
 tb/tb_fsm_steer_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_steer_driver.sv
// Steers the 4-state control FSM toward a requested state one legal hop at a time.
// Each hop is checked, and the controller reports either done or an error code.
//   state | meaning
//   IDLE  | ready; accept a target request
//   STEP  | compare observed state with target, launch next hop
//   WAIT  | hold hop drive until expected state, detour or timeout
//   DONE  | one-cycle done pulse
//   ERR   | one-cycle err pulse
module fsm_steer_driver #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_state,
  input  logic [1:0] i_fsm_state,
  output logic       o_drv_a,
  output logic       o_drv_b,
  output logic       o_drv_c,
  output logic       o_drv_d,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [1:0] EC_NONE    = 2'b00;
  localparam logic [1:0] EC_UNREACH = 2'b01;
  localparam logic [1:0] EC_TIMEOUT = 2'b10;
  localparam logic [1:0] EC_UNEXP   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           r_state;
  logic [1:0]       r_tgt;
  logic [1:0]       r_exp;
  logic [1:0]       r_org;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hold_a;
  logic             r_drv_a;
  logic             r_drv_b;
  logic             r_drv_c;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic w_at_exp;
  logic w_at_org;
  logic w_unreach;

  assign w_at_exp  = (i_fsm_state == r_exp);
  assign w_at_org  = (i_fsm_state == r_org);
  // S1 is absorbing and S0 has no way back in.
  assign w_unreach = (i_fsm_state == S1) || (r_tgt == S0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tgt      <= S0;
      r_exp      <= S0;
      r_org      <= S0;
      r_cnt      <= '0;
      r_hold_a   <= 1'b0;
      r_drv_a    <= 1'b0;
      r_drv_b    <= 1'b0;
      r_drv_c    <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= EC_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_tgt      <= i_req_state;
            r_err_code <= EC_NONE;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_org <= i_fsm_state;
          r_cnt <= '0;
          if (i_fsm_state == r_tgt) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_unreach) begin
            r_err      <= 1'b1;
            r_err_code <= EC_UNREACH;
            r_state    <= ST_ERR;
          end else begin
            r_state <= ST_WAIT;
            case (i_fsm_state)
              S0: begin
                if (r_tgt == S1) begin
                  r_drv_b <= 1'b1;
                  r_drv_c <= 1'b0;
                  r_exp   <= S1;
                end else begin
                  r_drv_c <= 1'b1;
                  r_drv_b <= 1'b0;
                  r_exp   <= S2;
                end
              end
              S2: begin
                if (r_tgt == S1) begin
                  r_drv_b <= 1'b1;
                  r_drv_a <= 1'b0;
                  r_exp   <= S1;
                end else begin
                  r_drv_a <= 1'b1;
                  r_drv_b <= 1'b0;
                  r_exp   <= S3;
                end
              end
              default: begin
                r_drv_a  <= 1'b0;
                r_hold_a <= 1'b0;
                r_exp    <= S2;
              end
            endcase
          end
        end
        ST_WAIT: begin
          // A match is checked first so it wins over a same-cycle timeout.
          if (w_at_exp) begin
            r_drv_b  <= 1'b0;
            r_drv_c  <= 1'b0;
            r_hold_a <= (r_exp == S3);
            r_drv_a  <= (r_exp == S3);
            r_state  <= ST_STEP;
          end else if (!w_at_org || (r_cnt == CNT_LAST)) begin
            r_drv_b    <= 1'b0;
            r_drv_c    <= 1'b0;
            r_drv_a    <= r_hold_a;
            r_err      <= 1'b1;
            r_err_code <= w_at_org ? EC_TIMEOUT : EC_UNEXP;
            r_state    <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_drv_a     = r_drv_a;
  assign o_drv_b     = r_drv_b;
  assign o_drv_c     = r_drv_c;
  assign o_drv_d     = 1'b0;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_fsm_steer_driver.sv
// Bench for fsm_steer_driver: a behavioural 4-state FSM plus a hop-plan model that
// predicts every output cycle by cycle, with directed fault and reset scenarios.
module tb_fsm_steer_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [1:0] i_req_state;
  logic [1:0] i_fsm_state;
  logic       o_drv_a;
  logic       o_drv_b;
  logic       o_drv_c;
  logic       o_drv_d;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [1:0] o_err_code;

  always #5 clk = ~clk;

  fsm_steer_driver #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_state (i_req_state),
    .i_fsm_state (i_fsm_state),
    .o_drv_a     (o_drv_a),
    .o_drv_b     (o_drv_b),
    .o_drv_c     (o_drv_c),
    .o_drv_d     (o_drv_d),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic       a;
    logic       b;
    logic       c;
  } exp_t;

  exp_t       sched[$];
  int         checks = 0;
  int         errors = 0;
  bit         model_on = 1'b0;
  logic [1:0] last_code = 2'b00;

  // Controlled FSM: reacts on the falling edge after a drive appears.
  logic [1:0] fsm_q = 2'b00;
  bit         freeze = 1'b0;
  bit         force_en = 1'b0;
  logic [1:0] force_val = 2'b00;
  assign i_fsm_state = fsm_q;

  always @(negedge clk) begin
    if (force_en) fsm_q <= force_val;
    else if (!freeze) begin
      case (fsm_q)
        2'b00: if (o_drv_b) fsm_q <= 2'b01; else if (o_drv_c) fsm_q <= 2'b10;
        2'b10: if (o_drv_a) fsm_q <= 2'b11; else if (o_drv_b) fsm_q <= 2'b01;
        2'b11: if (!o_drv_a) fsm_q <= 2'b10;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic busy, input logic dn, input logic er,
                              input logic [1:0] code, input logic a, input logic b, input logic c);
    return exp_t'({busy, dn, er, code, a, b, c});
  endfunction

  // Path planner from the hop rules: one STEP per visited state, one WAIT per hop.
  task automatic plan(input logic [1:0] cur0, input logic [1:0] tgt,
                      output logic [1:0] fin, output logic [1:0] code);
    logic [1:0] cur;
    logic [1:0] nxt;
    logic       hold, a, b, c;
    cur  = cur0;
    fin  = cur0;
    code = 2'b00;
    for (int hop = 0; hop < 4; hop++) begin
      hold = (cur == 2'b11);
      sched.push_back(mk(1, 0, 0, 2'b00, hold, 0, 0));
      if (cur == tgt) begin
        sched.push_back(mk(1, 1, 0, 2'b00, hold, 0, 0));
        fin = cur; code = 2'b00;
        return;
      end
      if (cur == 2'b01 || tgt == 2'b00) begin
        sched.push_back(mk(1, 0, 1, 2'b01, hold, 0, 0));
        fin = cur; code = 2'b01;
        return;
      end
      a = 0; b = 0; c = 0;
      case (cur)
        2'b00:   if (tgt == 2'b01) begin b = 1; nxt = 2'b01; end else begin c = 1; nxt = 2'b10; end
        2'b10:   if (tgt == 2'b01) begin b = 1; nxt = 2'b01; end else begin a = 1; nxt = 2'b11; end
        default: nxt = 2'b10;
      endcase
      sched.push_back(mk(1, 0, 0, 2'b00, a, b, c));
      cur = nxt;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (model_on && !rst) begin
      if (sched.size() > 0) e = sched.pop_front();
      else e = mk(0, 0, 0, last_code, (fsm_q == 2'b11), 0, 0);
      chk("busy", o_busy, e.busy);
      chk("req_ready", o_req_ready, !e.busy);
      chk("done", o_done, e.done);
      chk("err", o_err, e.err);
      chk("err_code", o_err_code, e.code);
      chk("drv_a", o_drv_a, e.a);
      chk("drv_b", o_drv_b, e.b);
      chk("drv_c", o_drv_c, e.c);
      chk("drv_d", o_drv_d, 1'b0);
      chk("inv_bc", o_drv_b & o_drv_c, 1'b0);
      chk("inv_ab", o_drv_a & o_drv_b, 1'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic force_fsm(input logic [1:0] v);
    @(negedge clk); #2;
    force_en = 1'b1; force_val = v;
    @(negedge clk); #2;
    force_en = 1'b0;
  endtask

  // lat = index of the pulse cycle, counting the cycle after the acceptance edge as 1.
  task automatic run_req(input logic [1:0] tgt, input bit use_model, input bit noise,
                         output int lat, output bit got_done, output bit got_err,
                         output logic [63:0] b_hist);
    logic [1:0] fin, code;
    int n;
    lat = 0; got_done = 0; got_err = 0; b_hist = '0; n = 0; fin = fsm_q; code = 2'b00;
    @(negedge clk); #2;
    i_req_valid = 1'b1; i_req_state = tgt;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (use_model) begin
      plan(fsm_q, tgt, fin, code);
      n = sched.size();
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #2;
      b_hist[k] = o_drv_b;
      if (o_done || o_err) begin
        lat = k; got_done = o_done; got_err = o_err;
        break;
      end
      if (noise) begin
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_state = 2'($urandom_range(0, 3));
      end
    end
    i_req_valid = 1'b0;
    chk("pulse_seen", (lat != 0), 1'b1);
    if (use_model) begin
      chk("latency", lat, n);
      chk("final_state", fsm_q, fin);
      last_code = code;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          gd, ge;
    logic [63:0] bh;
    rst = 1'b1; i_req_valid = 1'b0; i_req_state = 2'b00;
    #12;
    chk("rst_outputs", {o_busy, o_done, o_err, o_err_code, o_drv_a, o_drv_b, o_drv_c, o_drv_d}, 9'h000);
    chk("rst_ready", o_req_ready, 1'b1);
    @(negedge clk); rst = 1'b0;
    idle(2);
    model_on = 1'b1;

    // S0 -> S1: single hop, B for exactly one WAIT cycle.
    run_req(2'b01, 1, 0, lat, gd, ge, bh);
    chk("t1_lat", lat, 4);
    chk("t1_done", gd, 1'b1);
    chk("t1_drvb_one_wait", bh[4:1], 4'b0010);
    chk("t1_fsm_s1", fsm_q, 2'b01);
    chk("t1_code", o_err_code, 2'b00);

    force_fsm(2'b00);
    run_req(2'b00, 1, 0, lat, gd, ge, bh);
    chk("at_target_lat", lat, 2);
    chk("at_target_done", gd, 1'b1);

    // S0 -> S3: C hop then A hop; A must hold S3 while idle.
    run_req(2'b11, 1, 0, lat, gd, ge, bh);
    chk("t2_lat", lat, 6);
    idle(12);
    chk("t2_hold_s3", fsm_q, 2'b11);
    chk("t2_drv_a_idle", o_drv_a, 1'b1);

    // S3 -> S1: release A to S2, then B to S1.
    run_req(2'b01, 1, 0, lat, gd, ge, bh);
    chk("t3_lat", lat, 6);
    chk("t3_fsm_s1", fsm_q, 2'b01);
    chk("t3_drv_a_low", o_drv_a, 1'b0);

    // S1 -> S2 is unreachable.
    run_req(2'b10, 1, 0, lat, gd, ge, bh);
    chk("t4_lat", lat, 2);
    chk("t4_err", ge, 1'b1);
    chk("t4_code", o_err_code, 2'b01);
    chk("t4_no_drive", bh[2:1], 2'b00);

    // Stuck FSM: timeout after 8 WAIT cycles.
    force_fsm(2'b00);
    model_on = 1'b0; freeze = 1'b1;
    run_req(2'b01, 0, 0, lat, gd, ge, bh);
    chk("t5_lat", lat, 10);
    chk("t5_err", ge, 1'b1);
    chk("t5_code", o_err_code, 2'b10);
    chk("t5_drvb_held", bh[9:2], 8'hFF);
    chk("t5_drvb_cleared", o_drv_b, 1'b0);
    freeze = 1'b0; last_code = 2'b10; model_on = 1'b1;
    idle(2);
    run_req(2'b00, 1, 0, lat, gd, ge, bh);
    chk("t5_recover_done", gd, 1'b1);
    chk("t5_code_cleared", o_err_code, 2'b00);

    // Detour to S3 during an S0 -> S1 hop.
    model_on = 1'b0;
    fork
      run_req(2'b01, 0, 0, lat, gd, ge, bh);
      begin
        repeat (2) @(negedge clk);
        #1; force_en = 1'b1; force_val = 2'b11;
        @(negedge clk);
        #1; force_en = 1'b0;
      end
    join
    chk("t6_lat", lat, 3);
    chk("t6_err", ge, 1'b1);
    chk("t6_code", o_err_code, 2'b11);
    idle(3);

    // Reset in the middle of a WAIT.
    @(negedge clk); #2;
    i_req_valid = 1'b1; i_req_state = 2'b11;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #3;
    chk("t6r_busy_before", o_busy, 1'b1);
    chk("t6r_drv_a_before", o_drv_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6r_outputs", {o_busy, o_done, o_err, o_err_code, o_drv_a, o_drv_b, o_drv_c, o_drv_d}, 9'h000);
    chk("t6r_ready_in_rst", o_req_ready, 1'b1);
    @(negedge clk); #2; rst = 1'b0;
    idle(2);
    chk("t6r_ready_after", o_req_ready, 1'b1);
    chk("t6r_busy_after", o_busy, 1'b0);
    chk("t6r_code_after", o_err_code, 2'b00);
    last_code = 2'b00;
    model_on = 1'b1;

    // Random walk with request noise while busy.
    for (int i = 0; i < 40; i++) begin
      if (fsm_q == 2'b01 && $urandom_range(0, 2) != 0) force_fsm(2'b00);
      run_req(2'($urandom_range(0, 3)), 1, 1, lat, gd, ge, bh);
      idle($urandom_range(0, 3));
    end
    idle(3);
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
